wb_regfile_sb: RTL and testbench
================================

Name: wb_regfile_sb

Overview:
- Write-back end of the MEM/WB pipeline interface.
- Consumes the WB-stage outputs (ALU result, data-memory read data, RF data select) and forms the write-back value.
- Writes that value into a 32x32 register file, which serves two decode-stage read ports with same-cycle write bypass.
- A per-register pending-write scoreboard raises a decode stall until every in-flight write to a source register has retired.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero.
- DW, 32, data width.
- PEND_MAX, 3, maximum in-flight writes tracked per register; the counter width is clog2(PEND_MAX+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- WB_ALU_RES  in  DW  ALU result from MEM/WB.
- WB_DM_Q  in  DW  data-memory read data from MEM/WB.
- WB_RF_D_SEL  in  1  write-data select: 1 = WB_DM_Q, 0 = WB_ALU_RES.
- WB_RF_WE  in  1  write-back enable.
- WB_RF_WA  in  5  write-back destination register.
- ID_RA1  in  5  decode read address, port 1.
- ID_RA2  in  5  decode read address, port 2.
- ID_ISSUE  in  1  decode issues an instruction this cycle.
- ID_WE  in  1  issued instruction writes a register.
- ID_WA  in  5  issued instruction destination.
- ID_RD1  out  DW  read data, port 1.
- ID_RD2  out  DW  read data, port 2.
- WB_RF_D  out  DW  selected write-back value.
- ID_STALL  out  1  decode must hold; ID_ISSUE is ignored while high.
- SB_ERR  out  1  sticky scoreboard error.

Behaviour:
- Reset (async, rst=1):
  - all registers cleared to 0;
  - all pending counters cleared to 0;
  - SB_ERR cleared to 0.
  - Outputs during reset: ID_RD1/ID_RD2 = 0, ID_STALL = 0 unless an overflow condition exists, WB_RF_D follows its inputs.
  - Reset mid-operation discards every in-flight scoreboard entry; writes presented in the same cycle as reset are dropped.
- WB_RF_D (combinational): WB_RF_D_SEL ? WB_DM_Q : WB_ALU_RES.
- Write condition: "wr" = WB_RF_WE && WB_RF_WA != 0. On each rising edge with wr, regfile[WB_RF_WA] <= WB_RF_D. Writes to register 0 are discarded.
- Read ports (combinational, zero latency):
  - ID_RDn = 0 when ID_RAn == 0;
  - else WB_RF_D when wr && WB_RF_WA == ID_RAn (write-before-read bypass);
  - else regfile[ID_RAn].
- Scoreboard, per register r != 0, counter cnt[r]:
  - "issue_r" = ID_ISSUE && !ID_STALL && ID_WE && ID_WA == r.
  - "retire_r" = wr && WB_RF_WA == r.
  - issue_r only: cnt += 1.
  - retire_r only: cnt -= 1.
  - Both in the same cycle: cnt unchanged.
  - retire_r with cnt == 0 and no issue_r: cnt stays 0 and SB_ERR <= 1 (sticky until reset).
  - cnt[0] is always 0; issues to register 0 are not tracked.
- "busy(r)" = r != 0 && cnt[r] != 0 && !(retire_r && cnt[r] == 1). A last write retiring this cycle is covered by the bypass and does not stall.
- ID_STALL (combinational) is high when any of these holds:
  - busy(ID_RA1);
  - busy(ID_RA2);
  - ID_WE && ID_WA != 0 && cnt[ID_WA] == PEND_MAX && !retire for ID_WA (overflow guard).
  - ID_STALL does not depend on ID_ISSUE, so it has no combinational loop.
- Stalled cycles: no counter increments; retirements continue.
- Latency:
  - a register written at edge N is readable from the array in cycle N+1, and through the bypass in cycle N;
  - a stall clears in the same cycle as the final retiring write.

Test Plan:
1. Reset then read: rst pulse; ID_RA1=5, ID_RA2=0 -> ID_RD1=0, ID_RD2=0, ID_STALL=0, SB_ERR=0.
2. Write-back mux and bypass:
   - WB_RF_WE=1, WB_RF_WA=7, WB_ALU_RES=0x1234, WB_DM_Q=0xBEEF, WB_RF_D_SEL=1, ID_RA1=7 -> same cycle WB_RF_D=0xBEEF and ID_RD1=0xBEEF;
   - next cycle, with WE=0 -> ID_RD1=0xBEEF.
3. Register 0 protection: write 0xFFFFFFFF to WA=0 -> ID_RD1 with RA1=0 stays 0; no counter change; SB_ERR=0.
4. Load-use stall:
   - issue with ID_WE=1, ID_WA=3; next cycle ID_RA2=3 -> ID_STALL=1;
   - 3 cycles later retire WA=3 with WB_ALU_RES=0x55 -> same cycle ID_STALL=0, ID_RD2=0x55.
5. Multiple in-flight writes and overflow:
   - issue to register 4 three times -> cnt=3;
   - a 4th issue attempt with ID_WA=4 -> ID_STALL=1 and cnt stays 3;
   - retire twice -> RA=4 still stalls; third retire -> stall drops.
6. Error and reset mid-op:
   - retire WA=9 with cnt=0 -> SB_ERR=1 and stays 1;
   - issue to register 2, then assert rst asynchronously mid-cycle -> cnt[2]=0 immediately, ID_STALL=0, SB_ERR=0.

Source files
------------

// File: rtl/wb_regfile_sb.sv
// Write-back stage: forms the write-back value, owns the 32x32 register file with
// same-cycle bypass, and tracks in-flight writes per register to stall decode.
module wb_regfile_sb #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned PEND_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] WB_ALU_RES,
  input  logic [DW-1:0] WB_DM_Q,
  input  logic          WB_RF_D_SEL,
  input  logic          WB_RF_WE,
  input  logic [4:0]    WB_RF_WA,
  input  logic [4:0]    ID_RA1,
  input  logic [4:0]    ID_RA2,
  input  logic          ID_ISSUE,
  input  logic          ID_WE,
  input  logic [4:0]    ID_WA,
  output logic [DW-1:0] ID_RD1,
  output logic [DW-1:0] ID_RD2,
  output logic [DW-1:0] WB_RF_D,
  output logic          ID_STALL,
  output logic          SB_ERR
);

  localparam int unsigned CW = $clog2(PEND_MAX + 1);
  localparam int unsigned AW = 5;

  logic                wr;
  logic [DW-1:0]       rf_q  [NREGS];
  logic [CW-1:0]       cnt_q [NREGS];
  logic [CW-1:0]       cnt_d [NREGS];
  logic                err_q;
  logic                err_d;
  logic [NREGS-1:0]    busy;
  logic                ovf;

  assign WB_RF_D = WB_RF_D_SEL ? WB_DM_Q : WB_ALU_RES;
  assign wr      = WB_RF_WE && (WB_RF_WA != '0);
  assign SB_ERR  = err_q;

  // Reads are forced to zero while reset is held, so a write presented during
  // reset never leaks out through the bypass.
  always_comb begin
    ID_RD1 = '0;
    ID_RD2 = '0;
    if (!rst && ID_RA1 != '0) begin
      ID_RD1 = (wr && WB_RF_WA == ID_RA1) ? WB_RF_D : rf_q[ID_RA1];
    end
    if (!rst && ID_RA2 != '0) begin
      ID_RD2 = (wr && WB_RF_WA == ID_RA2) ? WB_RF_D : rf_q[ID_RA2];
    end
  end

  // A register whose last pending write retires this cycle is served by the bypass.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      busy[r] = (cnt_q[r] != '0) &&
                !(wr && WB_RF_WA == AW'(r) && cnt_q[r] == CW'(1));
    end
  end

  always_comb begin
    ovf = ID_WE && (ID_WA != '0) && (cnt_q[ID_WA] == CW'(PEND_MAX)) &&
          !(wr && WB_RF_WA == ID_WA);
    ID_STALL = busy[ID_RA1] || busy[ID_RA2] || ovf;
  end

  always_comb begin
    logic issue;
    logic retire;
    err_d = err_q;
    issue  = 1'b0;
    retire = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      issue  = ID_ISSUE && !ID_STALL && ID_WE && (ID_WA == AW'(r));
      retire = wr && (WB_RF_WA == AW'(r));
      if (issue && !retire) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (retire && !issue) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (wr) begin
        rf_q[WB_RF_WA] <= WB_RF_D;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: write-back mux, bypass, r0, scoreboard stall,
// overflow guard, sticky error and asynchronous reset.
module tb_wb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WB_ALU_RES, WB_DM_Q;
  logic        WB_RF_D_SEL, WB_RF_WE;
  logic [4:0]  WB_RF_WA, ID_RA1, ID_RA2, ID_WA;
  logic        ID_ISSUE, ID_WE;
  logic [31:0] ID_RD1, ID_RD2, WB_RF_D;
  logic        ID_STALL, SB_ERR;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .WB_ALU_RES (WB_ALU_RES),
    .WB_DM_Q    (WB_DM_Q),
    .WB_RF_D_SEL(WB_RF_D_SEL),
    .WB_RF_WE   (WB_RF_WE),
    .WB_RF_WA   (WB_RF_WA),
    .ID_RA1     (ID_RA1),
    .ID_RA2     (ID_RA2),
    .ID_ISSUE   (ID_ISSUE),
    .ID_WE      (ID_WE),
    .ID_WA      (ID_WA),
    .ID_RD1     (ID_RD1),
    .ID_RD2     (ID_RD2),
    .WB_RF_D    (WB_RF_D),
    .ID_STALL   (ID_STALL),
    .SB_ERR     (SB_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    WB_ALU_RES = '0; WB_DM_Q = '0; WB_RF_D_SEL = 1'b0; WB_RF_WE = 1'b0; WB_RF_WA = '0;
    ID_RA1 = '0; ID_RA2 = '0; ID_ISSUE = 1'b0; ID_WE = 1'b0; ID_WA = '0;

    // Write presented during reset: visible on WB_RF_D, dropped everywhere else
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd5; WB_ALU_RES = 32'h0000_00AA; ID_RA1 = 5'd5;
    settle();
    chk("rst_wbd", WB_RF_D, 32'h0000_00AA);
    chk("rst_rd1", ID_RD1, 32'h0);
    tick(); tick();
    rst = 1'b0; WB_RF_WE = 1'b0;
    settle();
    // 1. Reset then read
    chk("t1_rd1", ID_RD1, 32'h0);
    chk("t1_rd2", ID_RD2, 32'h0);
    chk("t1_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t1_err", {31'b0, SB_ERR}, 32'h0);

    // 2. Issue to r7, then write-back through the mux with bypass
    tick();
    ID_ISSUE = 1'b1; ID_WE = 1'b1; ID_WA = 5'd7; ID_RA1 = 5'd0;
    settle();
    chk("t2_issue_stall", {31'b0, ID_STALL}, 32'h0);
    tick();
    ID_ISSUE = 1'b0; ID_WE = 1'b0; ID_RA1 = 5'd7;
    settle();
    chk("t2_pend_stall", {31'b0, ID_STALL}, 32'h1);
    tick();
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd7; WB_ALU_RES = 32'h1234; WB_DM_Q = 32'hBEEF;
    WB_RF_D_SEL = 1'b0;
    settle();
    chk("t2_wbd_alu", WB_RF_D, 32'h1234);
    chk("t2_byp_alu", ID_RD1, 32'h1234);
    chk("t2_last_stall", {31'b0, ID_STALL}, 32'h0);
    WB_RF_D_SEL = 1'b1;
    settle();
    chk("t2_wbd_dm", WB_RF_D, 32'hBEEF);
    chk("t2_byp_dm", ID_RD1, 32'hBEEF);
    tick();
    WB_RF_WE = 1'b0;
    settle();
    chk("t2_array", ID_RD1, 32'hBEEF);
    chk("t2_err", {31'b0, SB_ERR}, 32'h0);

    // 3. Register 0 protection
    tick();
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd0; WB_ALU_RES = 32'hFFFF_FFFF; WB_RF_D_SEL = 1'b0;
    ID_RA1 = 5'd0;
    settle();
    chk("t3_wbd", WB_RF_D, 32'hFFFF_FFFF);
    chk("t3_byp", ID_RD1, 32'h0);
    tick();
    WB_RF_WE = 1'b0;
    settle();
    chk("t3_rd1", ID_RD1, 32'h0);
    chk("t3_err", {31'b0, SB_ERR}, 32'h0);

    // 4. Load-use stall on r3
    ID_ISSUE = 1'b1; ID_WE = 1'b1; ID_WA = 5'd3;
    tick();
    ID_ISSUE = 1'b0; ID_WE = 1'b0; ID_RA2 = 5'd3;
    settle();
    chk("t4_stall0", {31'b0, ID_STALL}, 32'h1);
    tick(); tick();
    chk("t4_stall2", {31'b0, ID_STALL}, 32'h1);
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd3; WB_ALU_RES = 32'h55;
    settle();
    chk("t4_ret_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t4_ret_rd2", ID_RD2, 32'h55);
    tick();
    WB_RF_WE = 1'b0;
    settle();
    chk("t4_after_rd2", ID_RD2, 32'h55);
    chk("t4_after_stall", {31'b0, ID_STALL}, 32'h0);

    // 5. Three in-flight writes to r4, then overflow guard
    ID_RA2 = 5'd0; ID_RA1 = 5'd0;
    ID_ISSUE = 1'b1; ID_WE = 1'b1; ID_WA = 5'd4;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t5_issue%0d", i), {31'b0, ID_STALL}, 32'h0);
      tick();
    end
    settle();
    chk("t5_ovf", {31'b0, ID_STALL}, 32'h1);
    tick();
    ID_ISSUE = 1'b0; ID_WE = 1'b0; ID_RA1 = 5'd4;
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd4; WB_ALU_RES = 32'h41;
    settle();
    chk("t5_ret1_stall", {31'b0, ID_STALL}, 32'h1);
    tick();
    WB_ALU_RES = 32'h42;
    settle();
    chk("t5_ret2_stall", {31'b0, ID_STALL}, 32'h1);
    tick();
    WB_ALU_RES = 32'h43;
    settle();
    chk("t5_ret3_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t5_ret3_rd1", ID_RD1, 32'h43);
    tick();
    WB_RF_WE = 1'b0;
    settle();
    chk("t5_idle_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t5_idle_rd1", ID_RD1, 32'h43);
    chk("t5_err", {31'b0, SB_ERR}, 32'h0);

    // 6. Retire without issue sets sticky error; async reset clears everything
    WB_RF_WE = 1'b1; WB_RF_WA = 5'd9; WB_ALU_RES = 32'h9;
    settle();
    chk("t6_err_pre", {31'b0, SB_ERR}, 32'h0);
    tick();
    WB_RF_WE = 1'b0;
    settle();
    chk("t6_err_set", {31'b0, SB_ERR}, 32'h1);
    tick();
    chk("t6_err_sticky", {31'b0, SB_ERR}, 32'h1);
    ID_ISSUE = 1'b1; ID_WE = 1'b1; ID_WA = 5'd2;
    tick();
    ID_ISSUE = 1'b0; ID_WE = 1'b0; ID_RA1 = 5'd2; ID_RA2 = 5'd7;
    settle();
    chk("t6_stall", {31'b0, ID_STALL}, 32'h1);
    chk("t6_rd2_pre", ID_RD2, 32'hBEEF);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t6_rst_err", {31'b0, SB_ERR}, 32'h0);
    chk("t6_rst_rd2", ID_RD2, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("t6_post_stall", {31'b0, ID_STALL}, 32'h0);
    chk("t6_post_rd2", ID_RD2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
